// File: rtl/dcache_refill_ctrl_if.sv
// Signal bundle between the dcache, the refill controller and main memory.
// slave = refill controller view; master = cache + memory side that drives it.
interface dcache_refill_ctrl_if #(
    parameter int TAG_W    = 3,
    parameter int INDEX_W  = 10,
    parameter int OFFSET_W = 4,
    parameter int DATA_W   = 32
);
    localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;

    logic                miss_valid;
    logic [ADDR_W-1:0]   miss_addr;
    logic                miss_ready;
    logic                mem_req;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_ack;
    logic [DATA_W-1:0]   mem_rdata;
    logic                fill_we;
    logic [TAG_W-1:0]    fill_tag;
    logic [INDEX_W-1:0]  fill_index;
    logic [OFFSET_W-1:0] fill_offset;
    logic [DATA_W-1:0]   fill_data;
    logic                crit_valid;
    logic                fill_done;

    modport slave (
        input  miss_valid, miss_addr, mem_ack, mem_rdata,
        output miss_ready, mem_req, mem_addr,
        output fill_we, fill_tag, fill_index, fill_offset, fill_data, crit_valid, fill_done
    );

    modport master (
        output miss_valid, miss_addr, mem_ack, mem_rdata,
        input  miss_ready, mem_req, mem_addr,
        input  fill_we, fill_tag, fill_index, fill_offset, fill_data, crit_valid, fill_done
    );
endinterface

// File: rtl/dcache_refill_ctrl.sv
// Direct-mapped dcache line refill: critical-word-first, wrap-around fetch of
// one line from memory, streamed into the data array with early critical word.
module dcache_refill_ctrl #(
    parameter int TAG_W    = 3,
    parameter int INDEX_W  = 10,
    parameter int OFFSET_W = 4,
    parameter int DATA_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    dcache_refill_ctrl_if.slave  bus
);
    localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;
    localparam logic [OFFSET_W-1:0] LAST_CNT = '1;

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] off0;
    } line_req_t;

    state_t              state;
    line_req_t           req;
    logic [OFFSET_W-1:0] cnt;
    logic [OFFSET_W-1:0] cur_off;
    logic [OFFSET_W-1:0] nxt_off;

    // Offsets wrap naturally in OFFSET_W bits, giving the critical-first order.
    assign cur_off = req.off0 + cnt;
    assign nxt_off = cur_off + OFFSET_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            req             <= '0;
            cnt             <= '0;
            bus.miss_ready  <= 1'b1;
            bus.mem_req     <= 1'b0;
            bus.mem_addr    <= '0;
            bus.fill_we     <= 1'b0;
            bus.fill_tag    <= '0;
            bus.fill_index  <= '0;
            bus.fill_offset <= '0;
            bus.fill_data   <= '0;
            bus.crit_valid  <= 1'b0;
            bus.fill_done   <= 1'b0;
        end else begin
            bus.fill_we    <= 1'b0;
            bus.crit_valid <= 1'b0;
            bus.fill_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.miss_valid) begin
                        req            <= line_req_t'(bus.miss_addr[ADDR_W-1:0]);
                        cnt            <= '0;
                        bus.mem_req    <= 1'b1;
                        bus.mem_addr   <= bus.miss_addr;
                        bus.miss_ready <= 1'b0;
                        state          <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus.mem_ack) begin
                        bus.fill_we     <= 1'b1;
                        bus.fill_data   <= DATA_W'(bus.mem_rdata);
                        bus.fill_offset <= cur_off;
                        bus.fill_tag    <= req.tag;
                        bus.fill_index  <= req.index;
                        bus.crit_valid  <= (cnt == '0);
                        cnt             <= cnt + OFFSET_W'(1);
                        bus.mem_addr    <= {req.tag, req.index, nxt_off};
                        // Last word lands together with fill_done in DONE.
                        if (cnt == LAST_CNT) begin
                            bus.mem_req   <= 1'b0;
                            bus.fill_done <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
                DONE: begin
                    bus.miss_ready <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Self-checking bench for dcache_refill_ctrl: randomized memory latency and
// miss addresses against a line-level model of the critical-first refill.
module tb_dcache_refill_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    int   data_mode = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dcache_refill_ctrl_if bus ();
    dcache_refill_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [3:0]  off;
        logic [31:0] data;
        logic [2:0]  tag;
        logic [9:0]  idx;
        logic        crit;
        logic        done;
        int          c;
    } fill_t;

    fill_t       fills[$];
    logic [16:0] req_addrs[$];
    int          ack_cyc[$];
    int          acc, ready_cyc, done_cnt, crit_cnt, unstable;
    bit          timed_out;
    logic        post_req, post_we, post_ready;

    // Memory contents seen by the controller.
    function automatic logic [31:0] data_fn(input logic [16:0] a);
        if (data_mode == 0) return 32'hA000_0000 + {28'd0, a[3:0]};
        return {a[7:0], 7'd0, a} ^ 32'h5A5A_1234;
    endfunction

    // Line model: k-th word fetched is offset (off0 + k) mod 16 of the same line.
    function automatic logic [16:0] exp_addr(input logic [16:0] a, input int k);
        return {a[16:4], 4'((int'(a[3:0]) + k) % 16)};
    endfunction

    function automatic logic [50:0] exp_fill(input logic [16:0] a, input int k);
        logic [16:0] w;
        w = exp_addr(a, k);
        return {w[3:0], data_fn(w), a[16:14], a[13:4], 1'(k == 0), 1'(k == 15)};
    endfunction

    function automatic logic [50:0] got_fill(input int k);
        if (k >= fills.size()) return 'x;
        return {fills[k].off, fills[k].data, fills[k].tag, fills[k].idx, fills[k].crit, fills[k].done};
    endfunction

    // Issues one miss and plays memory; records what the controller did.
    task automatic do_fill(input logic [16:0] a, input int ack_pct, input int ack_every,
                           input int rst_after, input bit hold_second);
        logic        prev_req, prev_ack, ack;
        logic [16:0] prev_addr;
        bit          got_rst, fin;
        int          post_cnt;
        fills.delete(); req_addrs.delete(); ack_cyc.delete();
        ready_cyc = -1; done_cnt = 0; crit_cnt = 0; unstable = 0;
        prev_req = 0; prev_ack = 0; prev_addr = '0; got_rst = 0; fin = 0; post_cnt = 0;
        @(negedge clk);
        bus.miss_valid = 1'b1; bus.miss_addr = a; bus.mem_ack = 1'b0;
        @(negedge clk);
        acc = cyc - 1;
        for (int it = 0; it < 400 && !fin; it++) begin
            if (bus.fill_we)
                fills.push_back('{bus.fill_offset, bus.fill_data, bus.fill_tag, bus.fill_index,
                                  bus.crit_valid, bus.fill_done, cyc});
            if (bus.fill_done) done_cnt++;
            if (bus.crit_valid) crit_cnt++;
            if (bus.mem_req && prev_req && !prev_ack && bus.mem_addr !== prev_addr) unstable++;
            if (got_rst) begin
                if (post_cnt == 0) begin
                    post_req = bus.mem_req; post_we = bus.fill_we; post_ready = bus.miss_ready;
                end
                post_cnt++;
                fin = (post_cnt >= 20);
            end else if (bus.miss_ready) begin
                ready_cyc = cyc;
                fin = 1;
            end
            if (!fin) begin
                prev_req = bus.mem_req; prev_addr = bus.mem_addr;
                if (hold_second) bus.miss_addr = 17'h1_2345;
                else bus.miss_valid = 1'b0;
                rst = 1'b0;
                if (rst_after > 0 && !got_rst && fills.size() == rst_after) begin
                    rst = 1'b1; got_rst = 1;
                end
                if (got_rst) ack = 1'($urandom_range(0, 1));
                else if (!bus.mem_req) ack = 1'b0;
                else if (ack_every > 0) ack = ((it % ack_every) == ack_every - 1);
                else ack = (int'($urandom_range(0, 99)) < ack_pct);
                bus.mem_ack   = ack;
                bus.mem_rdata = ack ? data_fn(bus.mem_addr) : $urandom();
                if (ack && !got_rst) begin
                    req_addrs.push_back(bus.mem_addr); ack_cyc.push_back(cyc);
                end
                prev_ack = ack;
                @(negedge clk);
            end
        end
        timed_out = !fin;
        rst = 1'b0; bus.mem_ack = 1'b0;
        if (!hold_second) bus.miss_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.miss_valid = 1'b1; bus.miss_addr = 17'h1FFFF;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.miss_ready, bus.mem_req, bus.fill_we, bus.crit_valid, bus.fill_done} !== 5'b10000)
            $display("FAIL reset_ctl: got %b want 10000",
                     {bus.miss_ready, bus.mem_req, bus.fill_we, bus.crit_valid, bus.fill_done});
        else passed++;
        checks++;
        if (bus.mem_addr !== 17'd0) $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr);
        else passed++;
        checks++;
        if ({bus.fill_tag, bus.fill_index, bus.fill_offset, bus.fill_data} !== 49'd0)
            $display("FAIL reset_fill_fields: got %h want 0",
                     {bus.fill_tag, bus.fill_index, bus.fill_offset, bus.fill_data});
        else passed++;
        rst = 1'b0; bus.miss_valid = 1'b0; bus.mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.miss_ready, bus.mem_req} !== 2'b10)
            $display("FAIL reset_release: got %b want 10", {bus.miss_ready, bus.mem_req});
        else passed++;
    endtask

    task automatic test_wrapped();
        logic [16:0] a;
        a = 17'b100_1110000000_1011;
        data_mode = 0;
        do_fill(a, 0, 1, 0, 0);
        checks++;
        if (timed_out) $display("FAIL wrap_timeout: line never completed"); else passed++;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (k >= req_addrs.size() || req_addrs[k] !== exp_addr(a, k))
                $display("FAIL wrap_addr[%0d]: got %h want %h", k, req_addrs[k], exp_addr(a, k));
            else passed++;
            checks++;
            if (got_fill(k) !== exp_fill(a, k) || fills[k].c !== acc + 2 + k)
                $display("FAIL wrap_fill[%0d]: got %h @%0d want %h @%0d", k, got_fill(k),
                         (k < fills.size()) ? fills[k].c : -1, exp_fill(a, k), acc + 2 + k);
            else passed++;
        end
        checks++;
        if (fills.size() < 1 || fills[0].data !== 32'hA000_000B || fills[0].tag !== 3'b100
            || fills[0].idx !== 10'h380)
            $display("FAIL wrap_crit_word: got %h want data a000000b tag 4 idx 380", got_fill(0));
        else passed++;
        checks++;
        if (fills.size() != 16 || done_cnt != 1 || fills[15].c != acc + 17)
            $display("FAIL wrap_done: got n=%0d done=%0d want 16 words, done at %0d",
                     fills.size(), done_cnt, acc + 17);
        else passed++;
        checks++;
        if (ready_cyc != acc + 18) $display("FAIL wrap_ready: got %0d want %0d", ready_cyc, acc + 18);
        else passed++;
    endtask

    task automatic test_stall();
        logic [16:0] a;
        a = {3'($urandom()), 10'($urandom()), 4'd0};
        data_mode = 1;
        do_fill(a, 0, 3, 0, 0);
        checks++;
        if (timed_out) $display("FAIL stall_timeout: line never completed"); else passed++;
        checks++;
        if (unstable != 0) $display("FAIL stall_addr_stable: got %0d changes want 0", unstable);
        else passed++;
        checks++;
        if (fills.size() != 16 || done_cnt != 1)
            $display("FAIL stall_count: got %0d words %0d done want 16 and 1", fills.size(), done_cnt);
        else passed++;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (got_fill(k) !== exp_fill(a, k) || k >= ack_cyc.size() || fills[k].c != ack_cyc[k] + 1)
                $display("FAIL stall_fill[%0d]: got %h want %h", k, got_fill(k), exp_fill(a, k));
            else passed++;
        end
    endtask

    task automatic test_busy();
        logic [16:0] a;
        int n_we, n_crit, n_done;
        a = {3'd5, 10'($urandom()), 4'($urandom())};
        data_mode = 1;
        do_fill(a, 0, 1, 0, 1);
        n_we = 0;
        for (int k = 0; k < 16; k++) if (got_fill(k) !== exp_fill(a, k)) n_we++;
        checks++;
        if (timed_out || n_we != 0 || fills.size() != 16)
            $display("FAIL busy_first_line: got %0d bad words of %0d want 0 of 16", n_we, fills.size());
        else passed++;
        checks++;
        if (ready_cyc != acc + 18) $display("FAIL busy_ignored: ready at %0d want %0d", ready_cyc, acc + 18);
        else passed++;
        @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.miss_ready, bus.mem_addr} !== {2'b10, 17'h1_2345})
            $display("FAIL busy_accept: got req=%b rdy=%b addr=%h want 1 0 12345",
                     bus.mem_req, bus.miss_ready, bus.mem_addr);
        else passed++;
        bus.miss_valid = 1'b0;
        n_we = 0; n_crit = 0; n_done = 0;
        for (int i = 0; i < 64 && !bus.miss_ready; i++) begin
            bus.mem_ack = bus.mem_req; bus.mem_rdata = $urandom();
            @(negedge clk);
            n_we += int'(bus.fill_we); n_crit += int'(bus.crit_valid); n_done += int'(bus.fill_done);
        end
        bus.mem_ack = 1'b0;
        checks++;
        if (!bus.miss_ready || n_we != 16 || n_crit != 1 || n_done != 1)
            $display("FAIL busy_second_line: got rdy=%b we=%0d crit=%0d done=%0d want 1 16 1 1",
                     bus.miss_ready, n_we, n_crit, n_done);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [16:0] a;
        data_mode = 1;
        a = 17'($urandom());
        do_fill(a, 70, 0, 5, 0);
        checks++;
        if (fills.size() != 5 || done_cnt != 0)
            $display("FAIL rstmid_words: got %0d words %0d done want 5 and 0", fills.size(), done_cnt);
        else passed++;
        checks++;
        if ({post_req, post_we, post_ready} !== 3'b001)
            $display("FAIL rstmid_after: got req/we/rdy %b want 001", {post_req, post_we, post_ready});
        else passed++;
        a = 17'($urandom());
        do_fill(a, 100, 0, 0, 0);
        checks++;
        if (timed_out || fills.size() != 16 || got_fill(0) !== exp_fill(a, 0) || done_cnt != 1)
            $display("FAIL rstmid_restart: got first %h n=%0d want %h n=16",
                     got_fill(0), fills.size(), exp_fill(a, 0));
        else passed++;
    endtask

    task automatic test_spurious();
        int bad;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            bus.mem_ack = 1'b1; bus.mem_rdata = $urandom();
            @(negedge clk);
            if (bus.fill_we || bus.crit_valid || bus.fill_done || bus.mem_req || !bus.miss_ready) bad++;
        end
        bus.mem_ack = 1'b0;
        checks++;
        if (bad != 0) $display("FAIL spurious_ack: got %0d disturbed cycles want 0", bad);
        else passed++;
    endtask

    task automatic test_random();
        logic [16:0] a;
        int errs;
        data_mode = 1;
        for (int i = 0; i < 6; i++) begin
            a = 17'($urandom());
            if (i == 0) a[3:0] = 4'd0;
            do_fill(a, int'($urandom_range(30, 100)), 0, 0, 0);
            errs = 0;
            for (int k = 0; k < 16; k++) begin
                if (got_fill(k) !== exp_fill(a, k)) errs++;
                else if (k >= ack_cyc.size() || fills[k].c != ack_cyc[k] + 1) errs++;
                if (k >= req_addrs.size() || req_addrs[k] !== exp_addr(a, k)) errs++;
            end
            checks++;
            if (timed_out || fills.size() != 16 || errs != 0)
                $display("FAIL rand%0d_line: got %0d words %0d errors want 16 and 0", i, fills.size(), errs);
            else passed++;
            checks++;
            if (unstable != 0) $display("FAIL rand%0d_stable: got %0d changes want 0", i, unstable);
            else passed++;
            checks++;
            if (crit_cnt != 1 || done_cnt != 1)
                $display("FAIL rand%0d_pulses: got crit=%0d done=%0d want 1 1", i, crit_cnt, done_cnt);
            else passed++;
            checks++;
            if (fills.size() != 16 || ready_cyc != fills[15].c + 1)
                $display("FAIL rand%0d_ready: got %0d want one cycle after last word", i, ready_cyc);
            else passed++;
        end
    endtask

    initial begin
        bus.miss_valid = 1'b0; bus.miss_addr = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        test_reset();
        test_wrapped();
        test_stall();
        test_busy();
        test_reset_mid();
        test_spurious();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/dcache_refill_ctrl.md
Name: dcache_refill_ctrl

Overview:
Miss-refill controller that sits directly downstream of the direct-mapped data cache (dcache), between it and main memory. It accepts one miss request (17-bit word address: 3-bit tag, 10-bit index, 4-bit word offset). It fetches the full 16-word line from memory critical-word-first with wrap-around, and writes each word back into the cache data array. It forwards the critical word early and signals line completion so the cache sets tag/valid only on a complete fill.

Parameters:
TAG_W, 3, tag field width (addr[16:14])
INDEX_W, 10, index field width (addr[13:4])
OFFSET_W, 4, word-offset width (addr[3:0]); line = 2^OFFSET_W words
DATA_W, 32, word width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
miss_valid  in  1  cache reports a miss; held until accepted
miss_addr  in  17  missing word address {tag,index,offset}
miss_ready  out  1  controller idle, miss accepted when miss_valid&miss_ready
mem_req  out  1  read request to memory
mem_addr  out  17  word address of current request
mem_ack  in  1  mem_rdata valid this cycle, current request complete
mem_rdata  in  32  memory read data
fill_we  out  1  write one word into cache data array
fill_tag  out  3  tag of line being filled
fill_index  out  10  line index being filled
fill_offset  out  4  word offset for fill_data
fill_data  out  32  word to write
crit_valid  out  1  one-cycle pulse: fill_data is the originally missed word
fill_done  out  1  one-cycle pulse: line complete, cache may set tag+valid

Behaviour:
- Single clock clk; reset rst is synchronous, active-high. All outputs are registered.
- Reset values: miss_ready=1, mem_req=0, mem_addr=0, fill_we=0, fill_tag=0, fill_index=0, fill_offset=0, fill_data=0, crit_valid=0, fill_done=0. State=IDLE, word counter cnt=0.
- States: IDLE, FETCH, DONE.
- IDLE: miss_ready=1. On miss_valid at edge N: latch tag/index/off0=miss_addr[3:0], set cnt=0, go to FETCH. From cycle N+1: mem_req=1, mem_addr={tag,index,off0}, miss_ready=0.
- FETCH: mem_req stays 1 and mem_addr stays stable until mem_ack. On mem_ack, at the next edge:
  - fill_we=1, fill_data=mem_rdata, fill_offset=off0+cnt (mod 16, wraps 15->0), fill_tag/fill_index = latched values.
  - crit_valid=1 iff cnt==0.
  - cnt increments.
  - mem_addr advances to offset off0+cnt+1 (mod 16).
- Back-to-back acks are legal, one word per cycle. Without mem_ack, fill_we=0 and nothing advances.
- Last word (cnt==15 with mem_ack): next edge goes to DONE and mem_req=0. In that DONE cycle fill_we=1 (last word) and fill_done=1 together. The next edge returns to IDLE with miss_ready=1.
- Minimum latency with ack every cycle:
  - miss accepted at edge N, acks in cycles N+1..N+16
  - fill_we asserted cycles N+2..N+17, crit_valid at N+2
  - fill_done at N+17, miss_ready=1 at N+18
- A miss with offset 0 issues offsets 0..15 in order, no wrap.
- miss_valid while not IDLE is ignored (miss_ready=0); upstream holds it.
- mem_ack outside FETCH is ignored. fill_we never asserts outside FETCH->FETCH/DONE transitions.
- rst mid-fill: all state returns to reset values at that edge; partially written words stay in the array. fill_done never asserts for the aborted line, so the line stays invalid.
- rst has priority over miss_valid and mem_ack in the same cycle.

Test Plan:
- Reset: hold rst 2 cycles with miss_valid=1, mem_ack=1 -> all outputs at reset values, no mem_req, miss_ready=1 after release.
- Wrapped critical-first fill: miss_addr=17'b100_1110000000_1011, mem_ack every cycle, mem_rdata=0xA000_0000+offset -> mem_addr offsets 11,12,13,14,15,0..10. fill_tag=3'b100, fill_index=10'h380. crit_valid with fill_data=0xA000000B at N+2; fill_done at N+17; miss_ready at N+18.
- Stalled memory: offset 0 miss, mem_ack every 3rd cycle -> mem_addr held stable between acks, offsets 0..15 in order, 16 fill_we pulses total, fill_done with the 16th.
- Busy rejection: assert a second miss_valid (addr 17'h1_2345) during FETCH -> ignored until IDLE, then accepted with mem_addr=17'h1_2345.
- Reset mid-fill: rst after 5 fill_we pulses -> next cycle mem_req=0, fill_we=0, no fill_done ever; a new miss restarts with cnt=0 and crit_valid on its first word.
- Spurious ack: mem_ack=1 while IDLE -> no fill_we, state unchanged.
